// File: rtl/debug_io_device.sv
// Debug I/O endpoint on the dbg membus: TX character FIFO, single-byte RX latch,
// and an exit sequencer that reports test completion once the TX FIFO has drained.
module debug_io_device #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned TX_DEPTH   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    bus_valid,
    output logic                    bus_ready,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    input  logic                    bus_wen,
    input  logic [DATA_WIDTH-1:0]   bus_wdata,
    input  logic [DATA_WIDTH/8-1:0] bus_wmask,
    output logic                    bus_rvalid,
    output logic [DATA_WIDTH-1:0]   bus_rdata,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [7:0]              tx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [7:0]              rx_data,
    output logic                    test_done,
    output logic                    test_success,
    output logic [DATA_WIDTH-1:0]   exit_code
);
    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] DEPTH_CNT = (PW + 1)'(TX_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state;
    logic [7:0]      fifo [TX_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [PW:0]     count;
    logic            rx_full;
    logic [7:0]      rx_byte;

    logic            fifo_full;
    logic            fifo_empty;
    logic            is_char;
    logic            accept;
    logic            push;
    logic            pop;
    logic            exit_cmd;
    logic            rx_pop;
    logic [DATA_WIDTH-1:0] read_word;
    logic            unused_bits;

    assign unused_bits = ^{bus_wmask, bus_addr[ADDR_WIDTH-1:4], bus_addr[2:0]};

    assign fifo_full  = (count == DEPTH_CNT);
    assign fifo_empty = (count == '0);
    assign is_char    = bus_wen && !bus_addr[3] && (bus_wdata[DATA_WIDTH-1 -: 20] == 20'h01010);

    assign bus_ready  = (state == RUN) && !(fifo_full && is_char);
    assign accept     = bus_valid && bus_ready;
    assign push       = accept && is_char;
    assign exit_cmd   = accept && bus_wen && !bus_addr[3] && !is_char && bus_wdata[0];
    assign rx_pop     = accept && !bus_wen && !bus_addr[3] && rx_full;

    // A DATA read emptying the latch lets a new byte be captured in the same cycle.
    assign rx_ready   = !rx_full || rx_pop;

    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo[rd_ptr];
    assign pop        = tx_valid && tx_ready;

    always_comb begin
        read_word = '0;
        if (bus_addr[3]) begin
            read_word[PW+8:8] = count;
            read_word[2]      = fifo_full;
            read_word[1]      = fifo_empty;
            read_word[0]      = rx_full;
        end else if (rx_full) begin
            read_word[7:0] = rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo[wr_ptr] <= bus_wdata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= RUN;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            rx_full      <= 1'b0;
            rx_byte      <= '0;
            bus_rvalid   <= 1'b0;
            bus_rdata    <= '0;
            test_done    <= 1'b0;
            test_success <= 1'b0;
            exit_code    <= '0;
        end else begin
            bus_rvalid <= accept;
            bus_rdata  <= (accept && !bus_wen) ? read_word : '0;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW + 1)'(push) - (PW + 1)'(pop);

            if (rx_valid && rx_ready) begin
                rx_full <= 1'b1;
                rx_byte <= rx_data;
            end else if (rx_pop) begin
                rx_full <= 1'b0;
            end

            case (state)
                RUN: begin
                    if (exit_cmd) begin
                        state        <= DRAIN;
                        exit_code    <= bus_wdata;
                        test_success <= (bus_wdata == DATA_WIDTH'(1));
                    end
                end
                DRAIN: begin
                    if (fifo_empty) begin
                        state     <= DONE;
                        test_done <= 1'b1;
                    end
                end
                default: state <= DONE;
            endcase
        end
    end
endmodule

// File: tb/tb_debug_io_device.sv
// Bench for debug_io_device: a queue-based behavioural model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_debug_io_device;
    logic        clk = 1'b0;
    logic        rst;
    logic        bus_valid;
    logic        bus_ready;
    logic [63:0] bus_addr;
    logic        bus_wen;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_wmask;
    logic        bus_rvalid;
    logic [63:0] bus_rdata;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        test_done;
    logic        test_success;
    logic [63:0] exit_code;

    debug_io_device #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .TX_DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_addr(bus_addr),
        .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
        .test_done(test_done), .test_success(test_success), .exit_code(exit_code)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [7:0]  mq[$];
    bit          m_rxf;
    logic [7:0]  m_rxb;
    bit          m_exit, m_done, m_succ, m_rvalid;
    logic [63:0] m_code, m_rdata;
    bit          known = 0;

    function automatic logic [63:0] ch(input logic [7:0] c);
        return 64'h0101_0000_0000_0000 | {56'h0, c};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit v, input bit a3, input bit w, input logic [63:0] d,
                         input bit txr, input bit rxv, input logic [7:0] rxd);
        rst       = 1'b1;
        bus_valid = v;
        bus_addr  = a3 ? 64'h8 : 64'h0;
        bus_wen   = w;
        bus_wdata = d;
        bus_wmask = 8'hFF;
        tx_ready  = txr;
        rx_valid  = rxv;
        rx_data   = rxd;
    endtask

    // Compare the DUT against the model, advance the model by one clock, move to next negedge.
    task automatic tick();
        bit full, empty, ischar, rdy, rxpop, rxr, acc, done_n;
        logic [63:0] rd;
        #1;
        full   = (mq.size() == 16);
        empty  = (mq.size() == 0);
        ischar = bus_wen && !bus_addr[3] && (bus_wdata[63:44] == 20'h01010);
        rdy    = !m_exit && !m_done && !(full && ischar);
        rxpop  = bus_valid && rdy && !bus_wen && !bus_addr[3] && m_rxf;
        rxr    = !m_rxf || rxpop;
        if (known) begin
            chk("bus_ready", bus_ready, rdy);
            chk("rx_ready", rx_ready, rxr);
            chk("tx_valid", tx_valid, !empty);
            if (!empty) chk("tx_data", tx_data, mq[0]);
            chk("bus_rvalid", bus_rvalid, m_rvalid);
            chk("bus_rdata", bus_rdata, m_rdata);
            chk("test_done", test_done, m_done);
            chk("test_success", test_success, m_succ);
            chk("exit_code", exit_code, m_code);
        end
        if (!rst) begin
            mq.delete();
            m_rxf = 0; m_rxb = 0; m_exit = 0; m_done = 0; m_succ = 0;
            m_rvalid = 0; m_code = 0; m_rdata = 0;
            known = 1;
        end else begin
            acc = bus_valid && rdy;
            if (bus_addr[3])
                rd = (64'(mq.size()) << 8) | {61'h0, full, empty, m_rxf};
            else
                rd = m_rxf ? {56'h0, m_rxb} : 64'h0;
            m_rvalid = acc;
            m_rdata  = (acc && !bus_wen) ? rd : 64'h0;
            done_n   = m_done || (m_exit && empty);
            if (done_n && !m_done) m_exit = 0;
            if (!empty && tx_ready) void'(mq.pop_front());
            if (acc && ischar) mq.push_back(bus_wdata[7:0]);
            if (acc && bus_wen && !bus_addr[3] && !ischar && bus_wdata[0]) begin
                m_exit = 1;
                m_code = bus_wdata;
                m_succ = (bus_wdata == 64'h1);
            end
            m_done = done_n;
            if (rxpop) m_rxf = 0;
            if (rx_valid && rxr) begin m_rxf = 1; m_rxb = rx_data; end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input bit v, input bit a3, input bit w, input logic [63:0] d,
                        input bit txr, input bit rxv, input logic [7:0] rxd);
        drive(v, a3, w, d, txr, rxv, rxd);
        tick();
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 64'h0, 0, 0, 8'h0);
        rst = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        bit acc;
        int txmode;
        int r;
        @(negedge clk);

        // 1: reset state and STATUS
        do_reset();
        chk("rst_done", test_done, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_rvalid", bus_rvalid, 0);
        chk("rst_code", exit_code, 0);
        step(1, 1, 0, 64'h0, 0, 0, 8'h0);
        chk("rst_status_rv", bus_rvalid, 1);
        chk("rst_status", bus_rdata, 64'h2);

        // 2: single character
        step(1, 0, 1, 64'h0101_0000_0000_0041, 1, 0, 8'h0);
        chk("c1_rvalid", bus_rvalid, 1);
        chk("c1_txv", tx_valid, 1);
        chk("c1_txd", tx_data, 8'h41);
        step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        step(1, 1, 0, 64'h0, 1, 0, 8'h0);
        chk("c1_status", bus_rdata, 64'h2);

        // 3: fill the FIFO, stall the 17th, then drain
        for (int i = 0; i < 16; i++)
            step(1, 0, 1, ch(8'h61 + 8'(i)), 0, 0, 8'h0);
        chk("full_head", tx_data, 8'h61);
        step(1, 1, 0, 64'h0, 0, 0, 8'h0);
        chk("full_status", bus_rdata, 64'h1004);
        drive(1, 0, 1, ch(8'h71), 0, 0, 8'h0);
        #1 chk("full_stall", bus_ready, 0);
        tick();
        step(1, 0, 1, ch(8'h71), 1, 0, 8'h0);
        acc = 0;
        for (int i = 0; i < 4 && !acc; i++) begin
            drive(1, 0, 1, ch(8'h71), 1, 0, 8'h0);
            #1 acc = bus_ready;
            tick();
        end
        chk("q17_accepted", acc, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        chk("drained_txv", tx_valid, 0);

        // 4: exit with pending characters
        for (int i = 0; i < 3; i++) step(1, 0, 1, ch(8'h30 + 8'(i)), 0, 0, 8'h0);
        step(1, 0, 1, 64'h1, 0, 0, 8'h0);
        drive(1, 0, 1, ch(8'h40), 0, 0, 8'h0);
        #1 chk("drain_ready", bus_ready, 0);
        tick();
        chk("drain_notdone", test_done, 0);
        step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        chk("last_pop_notdone", test_done, 0);
        step(0, 0, 0, 64'h0, 1, 0, 8'h0);
        chk("exit1_done", test_done, 1);
        chk("exit1_succ", test_success, 1);
        chk("exit1_code", exit_code, 64'h1);

        // 5: failing exit with an empty FIFO
        do_reset();
        step(1, 0, 1, 64'h7, 0, 0, 8'h0);
        chk("exit7_notyet", test_done, 0);
        step(0, 0, 0, 64'h0, 0, 0, 8'h0);
        chk("exit7_done", test_done, 1);
        chk("exit7_succ", test_success, 0);
        chk("exit7_code", exit_code, 64'h7);

        // 6: RX latch
        do_reset();
        step(0, 0, 0, 64'h0, 0, 1, 8'h5A);
        drive(0, 0, 0, 64'h0, 0, 0, 8'h0);
        #1 chk("rx_full_ready", rx_ready, 0);
        tick();
        step(1, 0, 0, 64'h0, 0, 0, 8'h0);
        chk("rx_read1", bus_rdata, 64'h5A);
        step(1, 0, 0, 64'h0, 0, 0, 8'h0);
        chk("rx_read2", bus_rdata, 64'h0);
        step(0, 0, 0, 64'h0, 0, 1, 8'h5A);
        drive(1, 0, 0, 64'h0, 0, 1, 8'h33);
        #1 chk("rx_pop_ready", rx_ready, 1);
        tick();
        chk("rx_pop_val", bus_rdata, 64'h5A);
        step(1, 0, 0, 64'h0, 0, 0, 8'h0);
        chk("rx_new_val", bus_rdata, 64'h33);

        // 7: randomized traffic
        do_reset();
        txmode = 1;
        for (int c = 0; c < 4000; c++) begin
            if (c % 50 == 0) txmode = $urandom_range(0, 3);
            r = $urandom % 1000;
            drive($urandom % 4 != 0, $urandom % 4 == 0, $urandom % 2 == 1, 64'h0,
                  (txmode == 0) ? 1'b0 : (txmode == 1) ? ($urandom % 4 == 0) : ($urandom % 4 != 0),
                  $urandom % 3 == 0, 8'($urandom));
            bus_addr = {$urandom, $urandom} & ~64'h8 | (bus_addr & 64'h8);
            if (r < 600)      bus_wdata = ch(8'($urandom));
            else if (r < 603) bus_wdata = (r == 600) ? 64'h1 : {32'h0, $urandom | 32'h1};
            else if (r < 800) bus_wdata = {$urandom, $urandom} & ~64'h1;
            else              bus_wdata = {$urandom, $urandom};
            bus_wmask = 8'($urandom);
            if ($urandom % 300 == 0) rst = 1'b0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
